vga_timing_generator: RTL and testbench

//  Free-running VGA raster timing source feeding pixel_generator. Divides the system clk into pixel

---
 rtl/gpu_timing_pkg.sv | 35 +++
 rtl/wrap_counter.sv | 46 ++++
 rtl/vga_timing_generator.sv | 145 ++++++++++++++
 tb/tb_vga_timing_generator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_timing_pkg.sv
// Shared 640x480@60 raster timing constants and small decode helpers for the VGA timing
// generator and pixel_generator.
package gpu_timing_pkg;

    localparam int unsigned VGA_DIV         = 4;
    localparam int unsigned VGA_H_VISIBLE   = 640;
    localparam int unsigned VGA_H_FRONT     = 16;
    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_BACK      = 48;
    localparam int unsigned VGA_H_TOTAL     = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_VISIBLE   = 480;
    localparam int unsigned VGA_V_FRONT     = 10;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_BACK      = 33;
    localparam int unsigned VGA_V_TOTAL     = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam logic        VGA_SYNC_ACTIVE = 1'b0;

    localparam int unsigned DIV_W      = 3;
    localparam int unsigned H_W        = 10;
    localparam int unsigned V_W        = 10;
    localparam int unsigned SCANLINE_W = 9;

    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
    } vga_ctrl_t;

    // True when val lies in the half-open window [lo, lo+len).
    function automatic logic in_window(input logic [9:0] val, input int unsigned lo,
                                       input int unsigned len);
        return (32'(val) >= lo) && (32'(val) < (lo + len));
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with increment enable; exposes the next value and a wrap strobe
// so a consumer can chain counters and decode state one clock ahead.
module wrap_counter
    import gpu_timing_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] next_c_o,
    output logic             wrap_c_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_c;

    always_comb begin
        count_d = count_q;
        wrap_c  = 1'b0;
        if (inc_i) begin
            if (count_q == WIDTH'(MAX)) begin
                count_d = '0;
                wrap_c  = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign next_c_o = count_d;
    assign wrap_c_o = wrap_c;

endmodule

// File: rtl/vga_timing_generator.sv
// Free-running VGA raster timing: pixel phase, position, blank/sync and frame strobe.
// Define VGA_TIMING_VBLANK_IRQ_EN to enable the sticky vertical-blank interrupt flag.
module vga_timing_generator
    import gpu_timing_pkg::*;
#(
    parameter int unsigned DIV         = VGA_DIV,
    parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT     = VGA_H_FRONT,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT     = VGA_V_FRONT,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter logic        SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  irq_ack,
    output logic [DIV_W-1:0]      divider_count,
    output logic                  pixel_clk,
    output logic [H_W-1:0]        cycle,
    output logic [SCANLINE_W-1:0] scanline,
    output logic                  vga_blank,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start,
    output logic                  vblank_irq
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;

    logic [DIV_W-1:0] div_count;
    logic [DIV_W-1:0] div_next;
    logic             div_wrap;
    logic [H_W-1:0]   h_count;
    logic [H_W-1:0]   h_next;
    logic             h_wrap;
    logic [V_W-1:0]   unused_v_count;
    logic [V_W-1:0]   v_next;
    logic             v_wrap;

    wrap_counter #(.WIDTH(DIV_W), .MAX(DIV - 1)) u_div_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (enable),
        .count_o  (div_count),
        .next_c_o (div_next),
        .wrap_c_o (div_wrap)
    );

    wrap_counter #(.WIDTH(H_W), .MAX(H_TOTAL - 1)) u_h_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (div_wrap),
        .count_o  (h_count),
        .next_c_o (h_next),
        .wrap_c_o (h_wrap)
    );

    wrap_counter #(.WIDTH(V_W), .MAX(V_TOTAL - 1)) u_v_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (h_wrap),
        .count_o  (unused_v_count),
        .next_c_o (v_next),
        .wrap_c_o (v_wrap)
    );

    vga_ctrl_t             ctrl_q;
    vga_ctrl_t             ctrl_d;
    logic [SCANLINE_W-1:0] scanline_q;
    logic [SCANLINE_W-1:0] scanline_d;
    logic                  pixel_clk_q;
    logic                  pixel_clk_d;
    logic                  frame_start_q;
    logic                  frame_start_d;
    logic                  irq_q;
    logic                  irq_d;

    // Decode from next-state counters so registered outputs line up with the counters.
    always_comb begin
        ctrl_d        = ctrl_q;
        scanline_d    = scanline_q;
        pixel_clk_d   = 1'b0;
        frame_start_d = 1'b0;
        irq_d         = 1'b0;

        ctrl_d.blank  = (h_next >= H_W'(H_VISIBLE)) || (v_next >= V_W'(V_VISIBLE));
        ctrl_d.hsync  = in_window(h_next, HS_START, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        ctrl_d.vsync  = in_window(v_next, VS_START, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        scanline_d    = v_next[SCANLINE_W-1:0];
        pixel_clk_d   = enable && (div_next == DIV_W'(DIV - 1));
        frame_start_d = div_wrap && h_wrap && v_wrap;

`ifdef VGA_TIMING_VBLANK_IRQ_EN
        // A new set beats a coincident acknowledge.
        if (div_wrap && h_wrap && (v_next == V_W'(V_VISIBLE))) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
`endif
    end

`ifndef VGA_TIMING_VBLANK_IRQ_EN
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q.blank  <= 1'b0;
            ctrl_q.hsync  <= ~SYNC_ACTIVE;
            ctrl_q.vsync  <= ~SYNC_ACTIVE;
            scanline_q    <= '0;
            pixel_clk_q   <= 1'b0;
            frame_start_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            scanline_q    <= scanline_d;
            pixel_clk_q   <= pixel_clk_d;
            frame_start_q <= frame_start_d;
            irq_q         <= irq_d;
        end
    end

    assign divider_count = div_count;
    assign cycle         = h_count;
    assign scanline      = scanline_q;
    assign pixel_clk     = pixel_clk_q;
    assign vga_blank     = ctrl_q.blank;
    assign hsync         = ctrl_q.hsync;
    assign vsync         = ctrl_q.vsync;
    assign frame_start   = frame_start_q;
    assign vblank_irq    = irq_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench for vga_timing_generator with a shrunk horizontal raster so whole frames
// fit in a short run; expectations for VGA_TIMING_VBLANK_IRQ_EN follow the same macro.
module tb_vga_timing_generator;

    localparam int unsigned T_DIV   = 4;
    localparam int unsigned T_HV    = 8;
    localparam int unsigned T_HF    = 2;
    localparam int unsigned T_HS    = 3;
    localparam int unsigned T_HB    = 3;
    localparam int unsigned T_VV    = 480;
    localparam int unsigned T_VF    = 10;
    localparam int unsigned T_VS    = 2;
    localparam int unsigned T_VB    = 33;
    localparam int unsigned T_HTOT  = T_HV + T_HF + T_HS + T_HB;
    localparam int unsigned T_VTOT  = T_VV + T_VF + T_VS + T_VB;
    localparam int unsigned LINE    = T_HTOT * T_DIV;
    localparam int unsigned FRAME   = LINE * T_VTOT;
`ifdef VGA_TIMING_VBLANK_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] div;
        logic [9:0] cyc;
        logic [8:0] sl;
        logic       pclk;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       irq;
    } obs_t;

    typedef struct {
        logic r;
        logic e;
        logic a;
        int   n;
        obs_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       irq_ack = 1'b0;
    logic [2:0] divider_count;
    logic       pixel_clk;
    logic [9:0] cycle;
    logic [8:0] scanline;
    logic       vga_blank;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic       vblank_irq;

    int checks = 0;
    int passes = 0;

    int unsigned m_t    = 0;
    logic        m_pclk = 1'b0;
    logic        m_fs   = 1'b0;
    logic        m_irq  = 1'b0;

    vga_timing_generator #(
        .DIV(T_DIV), .H_VISIBLE(T_HV), .H_FRONT(T_HF), .H_SYNC(T_HS), .H_BACK(T_HB),
        .V_VISIBLE(T_VV), .V_FRONT(T_VF), .V_SYNC(T_VS), .V_BACK(T_VB), .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .irq_ack(irq_ack),
        .divider_count(divider_count), .pixel_clk(pixel_clk), .cycle(cycle),
        .scanline(scanline), .vga_blank(vga_blank), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .vblank_irq(vblank_irq)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input int d, input int c, input int s, input logic p,
                                input logic b, input logic h, input logic v, input logic f,
                                input logic i);
        obs_t o;
        o.div = 3'(d); o.cyc = 10'(c); o.sl = 9'(s);
        o.pclk = p; o.blank = b; o.hs = h; o.vs = v; o.fs = f; o.irq = i;
        return o;
    endfunction

    // Raster position follows from the count of enabled clocks since reset.
    function automatic obs_t model_obs();
        int unsigned pos = m_t % FRAME;
        int unsigned pix = pos / T_DIV;
        int unsigned c   = pix % T_HTOT;
        int unsigned v   = pix / T_HTOT;
        obs_t o;
        o.div   = 3'(pos % T_DIV);
        o.cyc   = 10'(c);
        o.sl    = 9'(v % 512);
        o.pclk  = m_pclk;
        o.blank = (c >= T_HV) || (v >= T_VV);
        o.hs    = !((c >= T_HV + T_HF) && (c < T_HV + T_HF + T_HS));
        o.vs    = !((v >= T_VV + T_VF) && (v < T_VV + T_VF + T_VS));
        o.fs    = m_fs;
        o.irq   = m_irq;
        return o;
    endfunction

    task automatic model_update(input logic r, input logic e, input logic a);
        logic set;
        set = 1'b0;
        if (r) begin
            m_t = 0; m_pclk = 1'b0; m_fs = 1'b0; m_irq = 1'b0;
        end else begin
            if (e) begin
                m_t++;
                m_pclk = (m_t % T_DIV) == T_DIV - 1;
                m_fs   = (m_t % FRAME) == 0;
                set    = IRQ_ON && ((m_t % FRAME) == T_VV * LINE);
            end else begin
                m_pclk = 1'b0;
                m_fs   = 1'b0;
            end
            if (set) m_irq = 1'b1;
            else if (a) m_irq = 1'b0;
            m_irq = m_irq & IRQ_ON;
        end
    endtask

    function automatic obs_t dut_obs();
        return {divider_count, cycle, scanline, pixel_clk, vga_blank, hsync, vsync,
                frame_start, vblank_irq};
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        obs_t act;
        act = dut_obs();
        checks++;
        if (act !== exp)
            $display("FAIL %s t=%0d got div=%0d cyc=%0d sl=%0d pclk=%b blank=%b hs=%b vs=%b fs=%b irq=%b want div=%0d cyc=%0d sl=%0d pclk=%b blank=%b hs=%b vs=%b fs=%b irq=%b",
                     name, m_t, act.div, act.cyc, act.sl, act.pclk, act.blank, act.hs, act.vs,
                     act.fs, act.irq, exp.div, exp.cyc, exp.sl, exp.pclk, exp.blank, exp.hs,
                     exp.vs, exp.fs, exp.irq);
        else
            passes++;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s t=%0d got %0d want %0d", name, m_t, act, exp);
        else passes++;
    endtask

    task automatic step(input logic r, input logic e, input logic a);
        rst = r; enable = e; irq_ack = a;
        @(posedge clk);
        model_update(r, e, a);
        #2;
        check_obs("scoreboard", model_obs());
    endtask

    task automatic run_to(input int unsigned target);
        while (m_t < target) step(1'b0, 1'b1, 1'b0);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2,  mk(0, 0,  0, 0, 0, 1, 1, 0, 0)};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 3,  mk(3, 0,  0, 1, 0, 1, 1, 0, 0)};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1,  mk(0, 1,  0, 0, 0, 1, 1, 0, 0)};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 28, mk(0, 8,  0, 0, 1, 1, 1, 0, 0)};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8,  mk(0, 10, 0, 0, 1, 0, 1, 0, 0)};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 12, mk(0, 13, 0, 0, 1, 1, 1, 0, 0)};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 3,  mk(3, 13, 0, 1, 1, 1, 1, 0, 0)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 10, mk(3, 13, 0, 0, 1, 1, 1, 0, 0)};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1,  mk(0, 14, 0, 0, 1, 1, 1, 0, 0)};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8,  mk(0, 0,  1, 0, 0, 1, 1, 0, 0)};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1,  mk(0, 0,  0, 0, 0, 1, 1, 0, 0)};

        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].e, tbl[i].a);
            check_obs($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Entering the first blanked line, with an acknowledge landing on the same clock.
        run_to(T_VV * LINE - 1);
        step(1'b0, 1'b1, 1'b1);
        check_val("irq_set_vs_ack", 32'(vblank_irq), 32'(IRQ_ON));
        check_val("line480_scanline", 32'(scanline), 32'd480);
        check_val("line480_blank", 32'(vga_blank), 32'd1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0);
        check_val("irq_held", 32'(vblank_irq), 32'(IRQ_ON));
        step(1'b0, 1'b1, 1'b1);
        check_val("irq_cleared", 32'(vblank_irq), 32'd0);

        run_to(490 * LINE);
        check_val("vsync_on_490", 32'(vsync), 32'd0);
        run_to(492 * LINE);
        check_val("vsync_off_492", 32'(vsync), 32'd1);
        run_to(512 * LINE);
        check_val("line512_scanline", 32'(scanline), 32'd0);
        check_val("line512_blank", 32'(vga_blank), 32'd1);

        run_to(FRAME - 1);
        check_obs("frame_last", mk(3, 15, 12, 1, 1, 1, 1, 0, 0));
        step(1'b0, 1'b1, 1'b0);
        check_obs("frame_wrap", mk(0, 0, 0, 0, 0, 1, 1, 1, 0));
        step(1'b0, 1'b1, 1'b0);
        check_val("frame_pulse_end", 32'(frame_start), 32'd0);

        // Freeze mid-line, resume, then reset mid-frame.
        run_to(FRAME + (3 * T_HTOT + 5) * T_DIV + 3);
        for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 1'b0);
        check_obs("frozen", mk(3, 5, 3, 0, 0, 1, 1, 0, 0));
        step(1'b0, 1'b1, 1'b0);
        check_val("resume_cycle", 32'(cycle), 32'd6);
        step(1'b1, 1'b1, 1'b0);
        check_obs("midframe_reset", mk(0, 0, 0, 0, 0, 1, 1, 0, 0));

        for (int i = 0; i < 20000; i++)
            step(1'($urandom_range(0, 4999) == 0), 1'($urandom_range(0, 99) < 85),
                 1'($urandom_range(0, 49) == 0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
